// File: rtl/sr_drive_ctrl.sv
// Set/clear command sequencer for a gated SR flop: drives S or R for a fixed
// hold time, verifies Q feedback, and keeps saturating event counters.
module sr_drive_ctrl #(
  parameter int HOLD_CYCLES  = 2,
  parameter int CNT_W        = 4,
  parameter int PRIORITY_CLR = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             set_req,
  input  logic             clr_req,
  input  logic             q_fb,
  output logic             s_out,
  output logic             r_out,
  output logic             busy,
  output logic             ack,
  output logic             err,
  output logic [CNT_W-1:0] set_cnt,
  output logic [CNT_W-1:0] clr_cnt,
  output logic [CNT_W-1:0] conflict_cnt
);

  typedef enum logic [1:0] {IDLE, DRIVE_S, DRIVE_R, CHECK} state_e;

  localparam logic [3:0] HOLD_LD = 4'(HOLD_CYCLES - 1);

  state_e           state_q, state_d;
  logic [3:0]       hcnt_q, hcnt_d;
  logic             s_out_q, s_out_d;
  logic             r_out_q, r_out_d;
  logic             busy_q, busy_d;
  logic             ack_q, ack_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] set_cnt_q, set_cnt_d;
  logic [CNT_W-1:0] clr_cnt_q, clr_cnt_d;
  logic [CNT_W-1:0] conflict_cnt_q, conflict_cnt_d;
  logic             expected;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_d        = state_q;
    hcnt_d         = hcnt_q;
    ack_d          = 1'b0;
    err_d          = err_q;
    set_cnt_d      = set_cnt_q;
    clr_cnt_d      = clr_cnt_q;
    conflict_cnt_d = conflict_cnt_q;
    expected       = (state_q == DRIVE_S);

    unique case (state_q)
      IDLE: begin
        if (set_req && clr_req) begin
          state_d        = (PRIORITY_CLR != 0) ? DRIVE_R : DRIVE_S;
          hcnt_d         = HOLD_LD;
          conflict_cnt_d = sat_inc(conflict_cnt_q);
        end else if (set_req) begin
          state_d = DRIVE_S;
          hcnt_d  = HOLD_LD;
        end else if (clr_req) begin
          state_d = DRIVE_R;
          hcnt_d  = HOLD_LD;
        end
      end
      DRIVE_S, DRIVE_R: begin
        if (hcnt_q == 4'd0) begin
          // Q feedback is judged on the last drive edge so that ack can be
          // registered and still appear during the CHECK cycle.
          state_d = CHECK;
          if (q_fb == expected) begin
            ack_d = 1'b1;
            if (expected) set_cnt_d = sat_inc(set_cnt_q);
            else          clr_cnt_d = sat_inc(clr_cnt_q);
          end else begin
            err_d = 1'b1;
          end
        end else begin
          hcnt_d = hcnt_q - 4'd1;
        end
      end
      CHECK:   state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Output flops follow the next state, so S/R are mutually exclusive by construction.
    s_out_d = (state_d == DRIVE_S);
    r_out_d = (state_d == DRIVE_R);
    busy_d  = (state_d != IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update
  // together from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      hcnt_q         <= '0;
      s_out_q        <= 1'b0;
      r_out_q        <= 1'b0;
      busy_q         <= 1'b0;
      ack_q          <= 1'b0;
      err_q          <= 1'b0;
      set_cnt_q      <= '0;
      clr_cnt_q      <= '0;
      conflict_cnt_q <= '0;
    end else begin
      state_q        <= state_d;
      hcnt_q         <= hcnt_d;
      s_out_q        <= s_out_d;
      r_out_q        <= r_out_d;
      busy_q         <= busy_d;
      ack_q          <= ack_d;
      err_q          <= err_d;
      set_cnt_q      <= set_cnt_d;
      clr_cnt_q      <= clr_cnt_d;
      conflict_cnt_q <= conflict_cnt_d;
    end
  end

  assign s_out        = s_out_q;
  assign r_out        = r_out_q;
  assign busy         = busy_q;
  assign ack          = ack_q;
  assign err          = err_q;
  assign set_cnt      = set_cnt_q;
  assign clr_cnt      = clr_cnt_q;
  assign conflict_cnt = conflict_cnt_q;

endmodule

// File: tb/tb_sr_drive_ctrl.sv
// Directed bench for sr_drive_ctrl with a behavioural SR flop on q_fb and a
// second instance built with set-priority on conflicts.
module tb_sr_drive_ctrl;

  logic clk = 1'b0;
  logic rst, set_req, clr_req;
  logic stuck0;

  logic       q_fb, s_out, r_out, busy, ack, err;
  logic [3:0] set_cnt, clr_cnt, conflict_cnt;

  logic       q_fb_p0, s_out_p0, r_out_p0, busy_p0, ack_p0, err_p0;
  logic [3:0] set_cnt_p0, clr_cnt_p0, conflict_cnt_p0;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  sr_drive_ctrl #(.HOLD_CYCLES(2), .CNT_W(4), .PRIORITY_CLR(1)) dut (
    .clk(clk), .rst(rst), .set_req(set_req), .clr_req(clr_req), .q_fb(q_fb),
    .s_out(s_out), .r_out(r_out), .busy(busy), .ack(ack), .err(err),
    .set_cnt(set_cnt), .clr_cnt(clr_cnt), .conflict_cnt(conflict_cnt)
  );

  sr_drive_ctrl #(.HOLD_CYCLES(2), .CNT_W(4), .PRIORITY_CLR(0)) dut_p0 (
    .clk(clk), .rst(rst), .set_req(set_req), .clr_req(clr_req), .q_fb(q_fb_p0),
    .s_out(s_out_p0), .r_out(r_out_p0), .busy(busy_p0), .ack(ack_p0), .err(err_p0),
    .set_cnt(set_cnt_p0), .clr_cnt(clr_cnt_p0), .conflict_cnt(conflict_cnt_p0)
  );

  // Downstream SR flops; stuck0 models a flop whose Q will not rise.
  always_ff @(posedge clk) begin
    if (rst || stuck0) q_fb <= 1'b0;
    else if (s_out)    q_fb <= 1'b1;
    else if (r_out)    q_fb <= 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst)           q_fb_p0 <= 1'b0;
    else if (s_out_p0) q_fb_p0 <= 1'b1;
    else if (r_out_p0) q_fb_p0 <= 1'b0;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
  endtask

  // S and R must never be high together, on either instance, in any cycle.
  always @(negedge clk) begin
    check("s_and_r", {31'd0, s_out & r_out}, 32'd0);
    check("s_and_r_p0", {31'd0, s_out_p0 & r_out_p0}, 32'd0);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full command; returns one cycle after CHECK, with the DUT back in IDLE.
  task automatic do_cmd(input logic is_set, input logic exp_ack, input string tag);
    set_req = is_set;
    clr_req = ~is_set;
    step();
    set_req = 1'b0;
    clr_req = 1'b0;
    step();
    step();
    check({tag, "_ack"}, {31'd0, ack}, {31'd0, exp_ack});
    step();
  endtask

  initial begin
    rst = 1'b1; set_req = 1'b0; clr_req = 1'b0; stuck0 = 1'b0;
    step();
    step();
    check("rst_s", {31'd0, s_out}, 32'd0);
    check("rst_r", {31'd0, r_out}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_ack", {31'd0, ack}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_cnts", {20'd0, set_cnt, clr_cnt, conflict_cnt}, 32'd0);
    rst = 1'b0;
    step();
    check("idle_busy", {31'd0, busy}, 32'd0);

    // Basic set: S high for exactly two cycles, ack in the third.
    set_req = 1'b1;
    step();
    set_req = 1'b0;
    check("set_s_c1", {31'd0, s_out}, 32'd1);
    check("set_busy", {31'd0, busy}, 32'd1);
    step();
    check("set_s_c2", {31'd0, s_out}, 32'd1);
    check("set_ack_early", {31'd0, ack}, 32'd0);
    step();
    check("set_s_off", {31'd0, s_out}, 32'd0);
    check("set_ack", {31'd0, ack}, 32'd1);
    check("set_q", {31'd0, q_fb}, 32'd1);
    check("set_cnt1", {28'd0, set_cnt}, 32'd1);
    check("set_err", {31'd0, err}, 32'd0);
    step();
    check("set_ack_drop", {31'd0, ack}, 32'd0);
    check("set_idle", {31'd0, busy}, 32'd0);

    // Conflict: clear wins on dut, set wins on dut_p0.
    set_req = 1'b1; clr_req = 1'b1;
    step();
    set_req = 1'b0; clr_req = 1'b0;
    check("conf_r", {31'd0, r_out}, 32'd1);
    check("conf_s", {31'd0, s_out}, 32'd0);
    check("conf_p0_s", {31'd0, s_out_p0}, 32'd1);
    check("conf_p0_r", {31'd0, r_out_p0}, 32'd0);
    step();
    check("conf_r_c2", {31'd0, r_out}, 32'd1);
    step();
    check("conf_ack", {31'd0, ack}, 32'd1);
    check("conf_q", {31'd0, q_fb}, 32'd0);
    check("conf_clr_cnt", {28'd0, clr_cnt}, 32'd1);
    check("conf_cnt", {28'd0, conflict_cnt}, 32'd1);
    check("conf_p0_set_cnt", {28'd0, set_cnt_p0}, 32'd2);
    check("conf_p0_clr_cnt", {28'd0, clr_cnt_p0}, 32'd0);
    check("conf_p0_cnt", {28'd0, conflict_cnt_p0}, 32'd1);
    step();

    // clr_req raised during an active set is ignored, then taken once IDLE.
    set_req = 1'b1;
    step();
    set_req = 1'b0;
    clr_req = 1'b1;
    step();
    check("busy_ign_r", {31'd0, r_out}, 32'd0);
    check("busy_ign_s", {31'd0, s_out}, 32'd1);
    step();
    check("busy_ign_ack", {31'd0, ack}, 32'd1);
    check("busy_ign_clr_cnt", {28'd0, clr_cnt}, 32'd1);
    check("busy_ign_set_cnt", {28'd0, set_cnt}, 32'd2);
    step();
    check("busy_ign_idle_r", {31'd0, r_out}, 32'd0);
    check("busy_ign_idle_busy", {31'd0, busy}, 32'd0);
    step();
    clr_req = 1'b0;
    check("held_accept_r", {31'd0, r_out}, 32'd1);
    step();
    step();
    check("held_ack", {31'd0, ack}, 32'd1);
    check("held_clr_cnt", {28'd0, clr_cnt}, 32'd2);
    step();

    // Q stuck low: no ack, sticky err that survives good commands.
    stuck0 = 1'b1;
    do_cmd(1'b1, 1'b0, "stuck");
    check("stuck_err", {31'd0, err}, 32'd1);
    check("stuck_set_cnt", {28'd0, set_cnt}, 32'd2);
    stuck0 = 1'b0;
    do_cmd(1'b1, 1'b1, "good1");
    do_cmd(1'b0, 1'b1, "good2");
    do_cmd(1'b1, 1'b1, "good3");
    check("err_sticky", {31'd0, err}, 32'd1);
    check("good_set_cnt", {28'd0, set_cnt}, 32'd4);
    check("good_clr_cnt", {28'd0, clr_cnt}, 32'd3);

    // Reset in the middle of DRIVE_S abandons the command.
    set_req = 1'b1;
    step();
    set_req = 1'b0;
    check("mid_s", {31'd0, s_out}, 32'd1);
    rst = 1'b1;
    step();
    check("mid_rst_s", {31'd0, s_out}, 32'd0);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_err", {31'd0, err}, 32'd0);
    rst = 1'b0;
    step();
    check("mid_rst_ack", {31'd0, ack}, 32'd0);
    check("mid_rst_set_cnt", {28'd0, set_cnt}, 32'd0);
    check("mid_rst_idle_s", {31'd0, s_out}, 32'd0);

    // Saturation of set_cnt at 15.
    for (int i = 1; i <= 20; i++) begin
      do_cmd(1'b1, 1'b1, "sat");
      check("sat_set_cnt", {28'd0, set_cnt}, (i > 15) ? 32'd15 : 32'(i));
    end
    check("sat_err", {31'd0, err}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
